dmem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory port. It sits at the far end of the MEM-stage load/store interface.
- Accepts one word-sized load or store at a time and serves it from an internal word array after a configurable number of wait states.
- Holds the pipeline with stall_o until it returns a one-cycle ack_o, with read data or an error flag.
- Replaces the zero-latency memory model, so the pipeline's stall paths get exercised.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the CPU data-memory port. Serves one word-sized
//   load or store at a time from an internal word array. Each request completes
//   after a fixed number of wait states and ends with a one-cycle ack. While the
//   request is pending, the pipeline is held through stall_o.
//
//   State table:
//     IDLE | no transaction in flight; a request is accepted here
//     WAIT | good request pending, counting down wait states
//     RESP | ack cycle; rdata_o/err_o qualify the completed request
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (array contents are kept)
//   req_i    request valid; fields held stable until ack_o
//   we_i     1 = store, 0 = load
//   addr_i   byte address
//   wdata_i  store data
//   be_i     store byte enables (be_i[n] -> wdata_i[8n+7:8n])
//   stall_o  combinational pipeline hold
//   ack_o    registered one-cycle completion pulse
//   rdata_o  registered load data, held until the next ack
//   err_o    error qualifier, valid with ack_o
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int LAT   = (LATENCY < 1) ? 1 : LATENCY;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = (LAT > 1) ? CNT_W'(LAT - 2) : '0;
  localparam bit   SINGLE_CYCLE = (LAT == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;

  logic [31:0]        mem [2**ADDR_W];

  logic               req_err;
  logic               acc_en;
  logic               acc_we;
  logic [ADDR_W-1:0]  acc_idx;
  logic [31:0]        acc_wdata;
  logic [3:0]         acc_be;

  assign req_err = (addr_i[1:0] != 2'b00) || (addr_i[31:ADDR_W+2] != '0);

  assign stall_o = ((state == IDLE) && req_i) || (state == WAIT);

  // The array is touched on the edge that enters RESP. With a single-cycle
  // latency that edge leaves IDLE, so the live request fields are used;
  // otherwise the latched copy is used. A request that reaches WAIT is always
  // a good one, because error requests skip straight to RESP.
  always_comb begin
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state == IDLE) begin
      acc_we    = we_i;
      acc_idx   = addr_i[ADDR_W+1:2];
      acc_wdata = wdata_i;
      acc_be    = be_i;
      acc_en    = req_i && !req_err && SINGLE_CYCLE;
    end else if (state == WAIT) begin
      acc_en    = (cnt == '0);
    end
    // A reset on the committing edge abandons the store.
    if (rst_i) acc_en = 1'b0;
  end

  // The array is not reset, so it lives in its own process.
  always_ff @(posedge clk_i) begin
    if (acc_en && acc_we) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_be[n]) mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[ADDR_W+1:2];
            wdata_q <= wdata_i;
            be_q    <= be_i;
            if (req_err) begin
              state   <= RESP;
              ack_o   <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= '0;
            end else if (SINGLE_CYCLE) begin
              state <= RESP;
              ack_o <= 1'b1;
              if (!we_i) rdata_o <= mem[acc_idx];
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            ack_o <= 1'b1;
            if (!we_q) rdata_o <= mem[acc_idx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Scoreboard bench for dmem_responder. Main instance uses LATENCY=3; two
//   further instances (LATENCY=1 and LATENCY=0) share the same stimulus and
//   are examined only in the single-cycle scenario.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;

  logic        stall, ack, err;
  logic [31:0] rdata;
  logic        stall1, ack1, err1;
  logic [31:0] rdata1;
  logic        stall0, ack0, err0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .stall_o(stall), .ack_o(ack),
    .rdata_o(rdata), .err_o(err));

  dmem_responder #(.ADDR_W(8), .LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .stall_o(stall1), .ack_o(ack1),
    .rdata_o(rdata1), .err_o(err1));

  dmem_responder #(.ADDR_W(8), .LATENCY(0)) dut_l0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .stall_o(stall0), .ack_o(ack0),
    .rdata_o(rdata0), .err_o(err0));

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [256];
  logic [31:0] model_rd = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  int          ack_cyc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Drives one transaction to the LATENCY=3 instance. Starts just after a
  // rising edge; ends just after the edge closing the ack cycle with req still
  // asserted, so the caller can either issue the next request or go idle.
  task automatic txn(input string name, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    exp_t e, got_e;
    logic is_err;
    int   cyc, stalls;
    bit   got;
    is_err = (a[1:0] != 2'b00) || (a[31:10] != '0);
    if (is_err) model_rd = '0;
    else if (w) begin
      for (int n = 0; n < 4; n++) if (b[n]) mm[a[9:2]][8*n +: 8] = d[8*n +: 8];
    end else model_rd = mm[a[9:2]];
    e.err = is_err; e.rdata = model_rd; e.lat = is_err ? 1 : 3;
    sb.push_back(e);

    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    cyc = 0; stalls = 0; got = 0;
    while (!got && cyc <= 10) begin
      @(negedge clk);
      if (ack) begin
        got = 1;
        ack_cyc = cyc_cnt;
        got_e = sb.pop_front();
        checks++;
        if (cyc !== got_e.lat) begin
          errors++;
          $display("FAIL %s ack_latency: got %0d expected %0d", name, cyc, got_e.lat);
        end
        checks++;
        if (stalls !== got_e.lat) begin
          errors++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, got_e.lat);
        end
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_in_ack: got %b expected 0", name, stall);
        end
        checks++;
        if (err !== got_e.err) begin
          errors++;
          $display("FAIL %s err: got %b expected %b", name, err, got_e.err);
        end
        checks++;
        if (rdata !== got_e.rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h expected %h", name, rdata, got_e.rdata);
        end
      end else begin
        if (stall) stalls++;
        next_cycle();
        cyc++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s ack_timeout: got no ack expected ack within 10 cycles", name);
      void'(sb.pop_front());
    end
    next_cycle();
  endtask

  task automatic test_reset();
    req = 1'b0;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sb.delete();
    model_rd = '0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    next_cycle();
  endtask

  task automatic test_store_load();
    txn("store_full", 1'b1, 32'h10, 32'hCAFEF00D, 4'b1111);
    idle(1);
    txn("load_full", 1'b0, 32'h10, 32'h0, 4'b0000);
    checks++;
    if (rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL load_full_const: got %h expected cafef00d", rdata);
    end
    idle(1);
  endtask

  task automatic test_byte_enables();
    txn("store_base", 1'b1, 32'h20, 32'hAAAAAAAA, 4'b1111);
    idle(1);
    txn("store_be0101", 1'b1, 32'h20, 32'h11223344, 4'b0101);
    idle(1);
    txn("load_be0101", 1'b0, 32'h20, 32'h0, 4'b0000);
    checks++;
    if (rdata !== 32'hAA22AA44) begin
      errors++;
      $display("FAIL load_be0101_const: got %h expected aa22aa44", rdata);
    end
    idle(1);
    txn("store_be0000", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    idle(1);
    txn("load_be0000", 1'b0, 32'h20, 32'h0, 4'b0000);
    idle(1);
  endtask

  task automatic test_errors();
    txn("load_misaligned", 1'b0, 32'h13, 32'h0, 4'b0000);
    idle(1);
    txn("load_out_of_range", 1'b0, 32'h400, 32'h0, 4'b0000);
    idle(1);
    txn("store_misaligned", 1'b1, 32'h11, 32'h12345678, 4'b1111);
    idle(1);
    // 0x410 would alias word 0x10 if the range check were missing.
    txn("store_out_of_range", 1'b1, 32'h410, 32'h87654321, 4'b1111);
    idle(1);
    txn("load_untouched", 1'b0, 32'h10, 32'h0, 4'b0000);
    idle(1);
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3;
    txn("b2b_load0", 1'b0, 32'h10, 32'h0, 4'b0000);
    t1 = ack_cyc;
    txn("b2b_store", 1'b1, 32'h24, 32'h55667788, 4'b1111);
    t2 = ack_cyc;
    txn("b2b_load1", 1'b0, 32'h20, 32'h0, 4'b0000);
    t3 = ack_cyc;
    idle(1);
    checks++;
    if (t2 - t1 !== 4) begin errors++; $display("FAIL b2b_spacing1: got %0d expected 4", t2 - t1); end
    checks++;
    if (t3 - t2 !== 4) begin errors++; $display("FAIL b2b_spacing2: got %0d expected 4", t3 - t2); end
    txn("b2b_load_back", 1'b0, 32'h24, 32'h0, 4'b0000);
    idle(1);
  endtask

  task automatic test_reset_mid_store();
    txn("prefill_30", 1'b1, 32'h30, 32'h0BADBEEF, 4'b1111);
    idle(1);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h12345678; be = 4'b1111;
    next_cycle();            // first WAIT cycle
    next_cycle();            // second WAIT cycle
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    req = 1'b0;
    model_rd = '0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b expected 0", ack); end
    checks++;
    if (stall !== req) begin errors++; $display("FAIL rst_mid_stall: got %b expected %b", stall, req); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0", rdata); end
    next_cycle();
    txn("load_after_abort", 1'b0, 32'h30, 32'h0, 4'b0000);
    checks++;
    if (rdata !== 32'h0BADBEEF) begin
      errors++;
      $display("FAIL load_after_abort_const: got %h expected 0badbeef", rdata);
    end
    idle(1);
  endtask

  task automatic test_single_cycle();
    test_reset();
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hDEADBEEF; be = 4'b1111;
    @(negedge clk);
    checks++;
    if ({stall1, ack1, stall0, ack0} !== 4'b1010) begin
      errors++;
      $display("FAIL single_req_cycle: got stall1/ack1/stall0/ack0=%b expected 1010",
               {stall1, ack1, stall0, ack0});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({stall1, ack1, err1, stall0, ack0, err0} !== 6'b010010) begin
      errors++;
      $display("FAIL single_store_ack: got %b expected 010010",
               {stall1, ack1, err1, stall0, ack0, err0});
    end
    next_cycle();
    we = 1'b0; be = 4'b0000;
    @(negedge clk);
    checks++;
    if ({stall1, ack1, stall0, ack0} !== 4'b1010) begin
      errors++;
      $display("FAIL single_load_req: got %b expected 1010", {stall1, ack1, stall0, ack0});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ack1, ack0} !== 2'b11 || rdata1 !== 32'hDEADBEEF || rdata0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_load_ack: got ack1=%b ack0=%b rdata1=%h rdata0=%h expected 1 1 deadbeef deadbeef",
               ack1, ack0, rdata1, rdata0);
    end
    next_cycle();
    addr = 32'h13;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ack1, err1, ack0, err0} !== 4'b1111 || rdata1 !== 32'h0 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL single_err_ack: got ack1/err1/ack0/err0=%b rdata1=%h rdata0=%h expected 1111 0 0",
               {ack1, err1, ack0, err0}, rdata1, rdata0);
    end
    idle(2);
  endtask

  initial begin
    next_cycle();
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_back_to_back();
    test_reset_mid_store();
    test_single_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
